// File: rtl/traffic_pkg.sv
// traffic_pkg: shared mode codes, phase enum, light encodings and clog2 helper
package traffic_pkg;
  typedef enum logic [1:0] {MODE_NORMAL = 2'd0, MODE_ADJ_GR = 2'd1, MODE_ADJ_YR = 2'd2, MODE_ADJ_RR = 2'd3} mode_e;
  typedef enum logic [1:0] {PH_GREEN = 2'd0, PH_YELLOW = 2'd1, PH_ALLRED = 2'd2} phase_e;
  localparam logic [2:0] LIGHT_R   = 3'b100;
  localparam logic [2:0] LIGHT_Y   = 3'b010;
  localparam logic [2:0] LIGHT_G   = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// traffic_phase_sequencer_if: board-side controls in, light/direction/time display out
interface traffic_phase_sequencer_if
  import traffic_pkg::*;
#(
  parameter int NUM_DIRS = 2,
  parameter int TIME_W   = 4
);
  localparam int DW = clog2(NUM_DIRS);
  logic                  tick_i;
  logic [1:0]            mode_i;
  logic [2:0]            btn_i;
  logic                  flash_i;
  logic [3*NUM_DIRS-1:0] light_o;
  logic [DW-1:0]         dir_o;
  logic [TIME_W-1:0]     time_o;
  modport master (output tick_i, mode_i, btn_i, flash_i, input light_o, dir_o, time_o);
  modport slave (input tick_i, mode_i, btn_i, flash_i, output light_o, dir_o, time_o);
endinterface

// File: rtl/btn_edge_lockout.sv
// btn_edge_lockout: rising-edge detect with one shared lockout, lowest-index button wins
module btn_edge_lockout #(
  parameter int W         = 3,
  parameter int DB_CYCLES = 2**25
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] press_o
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [W-1:0]  prev_q;
  logic [W-1:0]  rise;
  logic [CW-1:0] lock_q, lock_d;
  // isolate the lowest set rising edge and reload the lockout on acceptance
  always_comb begin
    rise = btn_i & ~prev_q;
    press_o = (en_i && lock_q == '0) ? (rise & (~rise + 1'b1)) : '0;
    lock_d = |press_o ? CW'(DB_CYCLES) : lock_q - CW'(lock_q != '0);
  end
  // edge history always tracks the pins so edges inside lockout are consumed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
      lock_q <= '0;
    end else begin
      prev_q <= btn_i;
      lock_q <= lock_d;
    end
  end
endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: N-direction green/yellow/all-red sequencer with adjust and night flash
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_DIRS   = 2,
  parameter int TIME_W     = 4,
  parameter int DB_CYCLES  = 2**25,
  parameter int DEF_GREEN  = 8,
  parameter int DEF_YELLOW = 2,
  parameter int DEF_ALLRED = 1
) (
  input logic                     clk_i,
  input logic                     rst_i,
  traffic_phase_sequencer_if.slave bus_if
);
  localparam int DW = clog2(NUM_DIRS);
  localparam logic [TIME_W-1:0] MAX_T = '1;
  localparam logic [TIME_W-1:0] D_G = TIME_W'(DEF_GREEN);
  localparam logic [TIME_W-1:0] D_Y = TIME_W'(DEF_YELLOW);
  localparam logic [TIME_W-1:0] D_R = TIME_W'(DEF_ALLRED);
  localparam logic [3*NUM_DIRS-1:0] RST_LIGHT = {{(NUM_DIRS-1){LIGHT_R}}, LIGHT_G};

  phase_e                phase_q, phase_d;
  logic [DW-1:0]         dir_q, dir_d, dir_out_q;
  logic [TIME_W-1:0]     cnt_q, cnt_d;
  logic [TIME_W-1:0]     green_q, green_d, yellow_q, yellow_d, allred_q, allred_d;
  logic                  flash_q, flash_d, flash_prev_q, flash_act;
  logic [3*NUM_DIRS-1:0] light_q, light_d;
  logic [TIME_W-1:0]     time_q, time_d;
  logic [2:0]            ph_light;
  logic [2:0]            press;

  btn_edge_lockout #(.W(3), .DB_CYCLES(DB_CYCLES)) u_btn (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (bus_if.mode_i != MODE_NORMAL),
    .btn_i   (bus_if.btn_i),
    .press_o (press)
  );

  function automatic logic [TIME_W-1:0] adj_len(input logic [TIME_W-1:0] v, input logic [TIME_W-1:0] def, input logic [2:0] p);
    return p[0] ? def : p[1] ? (v == MAX_T ? v : v + 1'b1) : p[2] ? (v == TIME_W'(1) ? v : v - 1'b1) : v;
  endfunction

  // only the length selected by the adjust mode follows the accepted press
  always_comb begin
    green_d  = (bus_if.mode_i == MODE_ADJ_GR) ? adj_len(green_q, D_G, press) : green_q;
    yellow_d = (bus_if.mode_i == MODE_ADJ_YR) ? adj_len(yellow_q, D_Y, press) : yellow_q;
    allred_d = (bus_if.mode_i == MODE_ADJ_RR) ? adj_len(allred_q, D_R, press) : allred_q;
  end

  // next phase: frozen while flashing, restart on flash exit, otherwise count down per tick
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    flash_d = bus_if.flash_i ? flash_q ^ bus_if.tick_i : 1'b0;
    if (!bus_if.flash_i && flash_prev_q) begin
      phase_d = PH_GREEN;
      dir_d   = '0;
      cnt_d   = green_q;
    end else if (!bus_if.flash_i && bus_if.tick_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        phase_d = (phase_q == PH_GREEN) ? PH_YELLOW : (phase_q == PH_YELLOW) ? PH_ALLRED : PH_GREEN;
        dir_d   = (phase_q != PH_ALLRED) ? dir_q : (dir_q == DW'(NUM_DIRS - 1)) ? '0 : dir_q + 1'b1;
        cnt_d   = (phase_q == PH_GREEN) ? yellow_q : (phase_q == PH_YELLOW) ? allred_q : green_q;
      end
    end
  end

  // display: flash overrides adjust, adjust overrides the running sequence
  always_comb begin
    light_d   = '0;
    ph_light  = (phase_q == PH_GREEN) ? LIGHT_G : (phase_q == PH_YELLOW) ? LIGHT_Y : LIGHT_R;
    flash_act = bus_if.flash_i | flash_prev_q;
    for (int d = 0; d < NUM_DIRS; d++)
      light_d[3*d +: 3] = flash_act ? (flash_q ? LIGHT_Y : LIGHT_OFF) :
                          (bus_if.mode_i == MODE_ADJ_GR) ? ((d == 0) ? LIGHT_G : LIGHT_R) :
                          (bus_if.mode_i == MODE_ADJ_YR) ? LIGHT_Y :
                          (bus_if.mode_i == MODE_ADJ_RR) ? LIGHT_R :
                          (DW'(d) == dir_q) ? ph_light : LIGHT_R;
    time_d = flash_act ? '0 :
             (bus_if.mode_i == MODE_ADJ_GR) ? green_q :
             (bus_if.mode_i == MODE_ADJ_YR) ? yellow_q :
             (bus_if.mode_i == MODE_ADJ_RR) ? allred_q : cnt_q;
  end

  // sequencer state, flash bit and lengths
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q      <= PH_GREEN;
      dir_q        <= '0;
      cnt_q        <= D_G;
      flash_q      <= 1'b0;
      flash_prev_q <= 1'b0;
      green_q      <= D_G;
      yellow_q     <= D_Y;
      allred_q     <= D_R;
    end else begin
      phase_q      <= phase_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      flash_q      <= flash_d;
      flash_prev_q <= bus_if.flash_i;
      green_q      <= green_d;
      yellow_q     <= yellow_d;
      allred_q     <= allred_d;
    end
  end

  // registered outputs trail the state by one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      light_q   <= RST_LIGHT;
      time_q    <= D_G;
      dir_out_q <= '0;
    end else begin
      light_q   <= light_d;
      time_q    <= time_d;
      dir_out_q <= dir_q;
    end
  end

  assign bus_if.light_o = light_q;
  assign bus_if.dir_o   = dir_out_q;
  assign bus_if.time_o  = time_q;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: directed checks of sequencing, adjust, lockout, flash and reset
module tb_traffic_phase_sequencer;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  traffic_phase_sequencer_if #(.NUM_DIRS(3), .TIME_W(4)) bus ();

  traffic_phase_sequencer #(
    .NUM_DIRS(3), .TIME_W(4), .DB_CYCLES(4), .DEF_GREEN(8), .DEF_YELLOW(2), .DEF_ALLRED(1)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic press(input logic [2:0] v);
    @(negedge clk);
    bus.btn_i = v;
    @(negedge clk);
    bus.btn_i = 3'b000;
    repeat (8) @(negedge clk);
  endtask

  task automatic set_mode(input logic [1:0] m);
    bus.mode_i = m;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.tick_i  = 1'b0;
    bus.mode_i  = 2'd0;
    bus.btn_i   = 3'b000;
    bus.flash_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_light", bus.light_o, {R, R, G});
    check("rst_dir", bus.dir_o, 0);
    check("rst_time", bus.time_o, 8);

    for (int k = 7; k >= 0; k--) begin
      do_tick();
      check("green_cnt", bus.time_o, k);
    end
    check("green_light", bus.light_o, {R, R, G});
    do_tick();
    check("yellow_light", bus.light_o, {R, R, Y});
    check("yellow_time", bus.time_o, 2);
    ticks(2);
    check("yellow_end", bus.time_o, 0);
    do_tick();
    check("allred_light", bus.light_o, {R, R, R});
    check("allred_time", bus.time_o, 1);
    ticks(2);
    check("dir1_light", bus.light_o, {R, G, R});
    check("dir1_dir", bus.dir_o, 1);
    check("dir1_time", bus.time_o, 8);
    ticks(14);
    check("dir2_light", bus.light_o, {G, R, R});
    check("dir2_dir", bus.dir_o, 2);
    ticks(14);
    check("wrap_dir", bus.dir_o, 0);
    check("wrap_light", bus.light_o, {R, R, G});
    check("wrap_time", bus.time_o, 8);

    press(3'b010);
    set_mode(2'd1);
    check("normal_btn_ignored", bus.time_o, 8);
    check("adjgr_light", bus.light_o, {R, R, G});
    repeat (10) press(3'b010);
    check("green_sat", bus.time_o, 15);
    set_mode(2'd0);
    check("running_cnt_kept", bus.time_o, 8);
    ticks(14);
    check("long_green_dir", bus.dir_o, 1);
    check("long_green_time", bus.time_o, 15);
    ticks(15);
    check("long_green_end", bus.time_o, 0);
    do_tick();
    check("dir1_yellow", bus.light_o, {R, Y, R});

    set_mode(2'd2);
    check("adjyr_light", bus.light_o, {Y, Y, Y});
    check("adjyr_time", bus.time_o, 2);
    repeat (3) press(3'b100);
    check("yellow_floor", bus.time_o, 1);
    @(negedge clk);
    bus.btn_i = 3'b001;
    @(negedge clk);
    bus.btn_i = 3'b000;
    @(negedge clk);
    bus.btn_i = 3'b100;
    @(negedge clk);
    bus.btn_i = 3'b000;
    repeat (8) @(negedge clk);
    check("restore_lockout", bus.time_o, 2);

    set_mode(2'd3);
    check("adjrr_light", bus.light_o, {R, R, R});
    check("adjrr_time", bus.time_o, 1);
    press(3'b110);
    check("btn_priority", bus.time_o, 2);

    set_mode(2'd0);
    check("pre_flash_light", bus.light_o, {R, Y, R});
    bus.flash_i = 1'b1;
    repeat (3) @(negedge clk);
    check("flash_off0", bus.light_o, {O, O, O});
    check("flash_time", bus.time_o, 0);
    do_tick();
    check("flash_on1", bus.light_o, {Y, Y, Y});
    do_tick();
    check("flash_off2", bus.light_o, {O, O, O});
    check("flash_frozen_dir", bus.dir_o, 1);
    do_tick();
    check("flash_on3", bus.light_o, {Y, Y, Y});
    bus.flash_i = 1'b0;
    repeat (3) @(negedge clk);
    check("unflash_light", bus.light_o, {R, R, G});
    check("unflash_dir", bus.dir_o, 0);
    check("unflash_time", bus.time_o, 15);

    ticks(44 + 19 + 1);
    check("pre_rst_light", bus.light_o, {R, R, R});
    check("pre_rst_dir", bus.dir_o, 2);
    check("pre_rst_time", bus.time_o, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_light", bus.light_o, {R, R, G});
    check("async_rst_dir", bus.dir_o, 0);
    check("async_rst_time", bus.time_o, 8);
    @(negedge clk);
    rst = 1'b0;
    set_mode(2'd1);
    check("rst_green_len", bus.time_o, 8);
    set_mode(2'd2);
    check("rst_yellow_len", bus.time_o, 2);
    set_mode(2'd3);
    check("rst_allred_len", bus.time_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
